sigma_soc: RTL and testbench

//  Debug-accessible SoC shell for the sigma platform. A UART debug master (UDM) drives one internal 32-bit bus.
//  The bus holds on-chip RAM, LED/switch CSRs and an IRQ controller with a debounced button source.

---
 rtl/sigma_soc.sv | 218 +++++++++++++++++++++
 tb/tb_sigma_soc.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sigma_soc.sv
// sigma_soc: UART debug master (UDM) driving one internal 32-bit bus that holds
// on-chip RAM, LED/switch CSRs and a button IRQ controller. Processor slot is a stub.
module sigma_soc #(
    parameter string CPU                       = "riscv_1stage",
    parameter string UDM_RTX_EXTERNAL_OVERRIDE = "YES",
    parameter int    UART_BAUD_DIV             = 607,
    parameter int    DEBOUNCER_FACTOR_POW      = 2,
    parameter int    delay_test_flag           = 0,
    parameter string mem_init_type             = "none",
    parameter string mem_init_data             = "",
    parameter int    mem_size                  = 8192
) (
    input  logic        clk_i,
    input  logic        arst_i,
    input  logic        irq_btn_i,
    input  logic        rx_i,
    output logic        tx_o,
    input  logic [31:0] gpio_bi,
    output logic [31:0] gpio_bo,
    output logic        irq_o
);
    localparam int AW  = $clog2(mem_size);
    localparam int BW  = $clog2(UART_BAUD_DIV);
    localparam bit DLY = (delay_test_flag != 0);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_LEN, S_DATA, S_BUS, S_RESP} state_t;

    logic                r_rst_s1, r_srst, r_udm_rst;
    logic [1:0]          r_rx_s;
    logic                w_rx;
    logic                r_rx_busy, r_rx_vld;
    logic [BW-1:0]       r_rx_cnt, r_tx_cnt;
    logic [3:0]          r_rx_bit, r_tx_left;
    logic [7:0]          r_rx_sh;
    logic [9:0]          r_tx_sh;
    logic                w_tx_start, w_byte, w_sync;
    state_t              r_state, w_state_nxt;
    logic [1:0]          r_bcnt;
    logic [31:0]         r_addr, r_len, r_wdata, r_txbuf, w_len_new, w_rdata;
    logic [2:0]          r_txn;
    logic                r_we, r_busy, w_req, w_ack, w_is_ram;
    logic [31:0]         r_mem [mem_size];
    logic [31:0]         r_ram_q, r_csr_q, r_led, r_irq_en, r_gpio_s1, r_gpio_s2;
    logic                r_ack1, r_ack_d, r_ack2, r_sel_ram, r_pend, r_btn_db, w_btn_rise;
    logic [1:0]          r_btn_s;
    logic [DEBOUNCER_FACTOR_POW-1:0] r_db_cnt;

    // Processor slot: nothing instantiated in this revision for any core variant.
    if (CPU != "") begin : g_cpu_stub
    end

    // Internal reset: asserted with arst_i, released two clocks later unless UDM holds it.
    always_ff @(posedge clk_i or negedge arst_i)
        if (!arst_i) begin r_rst_s1 <= 1'b1; r_srst <= 1'b1; end
        else begin r_rst_s1 <= 1'b0; r_srst <= r_rst_s1 | r_udm_rst; end

    // RX line synchronizer; line held idle when the external override is off.
    always_ff @(posedge clk_i or negedge arst_i)
        if (!arst_i) r_rx_s <= 2'b11;
        else r_rx_s <= {r_rx_s[0], (UDM_RTX_EXTERNAL_OVERRIDE == "YES") ? rx_i : 1'b1};
    assign w_rx = r_rx_s[1];

    // UART receiver: find start edge, sample each bit at mid-bit, drop bytes with a bad stop bit.
    always_ff @(posedge clk_i or negedge arst_i)
        if (!arst_i) begin
            r_rx_busy <= 1'b0; r_rx_vld <= 1'b0; r_rx_cnt <= '0; r_rx_bit <= '0; r_rx_sh <= '0;
        end else begin
            r_rx_vld <= 1'b0;
            if (!r_rx_busy) begin
                if (!w_rx) begin
                    r_rx_busy <= 1'b1; r_rx_cnt <= BW'(UART_BAUD_DIV / 2); r_rx_bit <= '0;
                end
            end else if (r_rx_cnt != '0) r_rx_cnt <= r_rx_cnt - 1'b1;
            else begin
                r_rx_cnt <= BW'(UART_BAUD_DIV - 1);
                r_rx_bit <= r_rx_bit + 1'b1;
                if (r_rx_bit == 4'd0) begin
                    if (w_rx) r_rx_busy <= 1'b0;
                end else if (r_rx_bit == 4'd9) begin
                    r_rx_busy <= 1'b0; r_rx_vld <= w_rx;
                end else r_rx_sh <= {w_rx, r_rx_sh[7:1]};
            end
        end

    // UART transmitter: start bit, 8 data bits LSB first, stop bit; shifter idles at all ones.
    always_ff @(posedge clk_i or negedge arst_i)
        if (!arst_i) begin r_tx_sh <= '1; r_tx_left <= '0; r_tx_cnt <= '0; end
        else if (w_tx_start) begin
            r_tx_sh <= {1'b1, r_txbuf[7:0], 1'b0}; r_tx_left <= 4'd10; r_tx_cnt <= BW'(UART_BAUD_DIV - 1);
        end else if (r_tx_left != 4'd0) begin
            if (r_tx_cnt != '0) r_tx_cnt <= r_tx_cnt - 1'b1;
            else begin
                r_tx_sh <= {1'b1, r_tx_sh[9:1]}; r_tx_left <= r_tx_left - 1'b1;
                r_tx_cnt <= BW'(UART_BAUD_DIV - 1);
            end
        end
    assign tx_o = r_tx_sh[0];

    assign w_byte    = r_rx_vld;
    assign w_sync    = r_rx_vld && (r_rx_sh == 8'h55);
    assign w_len_new = {r_rx_sh, r_len[31:8]};

    // Parser state register.
    always_ff @(posedge clk_i or negedge arst_i)
        if (!arst_i) r_state <= S_IDLE;
        else r_state <= w_state_nxt;

    // Parser next state, bus request and reply-byte launch; a sync byte always restarts at CMD.
    always_comb begin
        w_state_nxt = r_state;
        w_req       = (r_state == S_BUS) && !r_busy;
        w_tx_start  = (r_state == S_RESP) && (r_txn != 3'd0) && (r_tx_left == 4'd0);
        if (w_sync) w_state_nxt = S_CMD;
        else begin
            case (r_state)
                S_CMD: if (w_byte) begin
                    case (r_rx_sh)
                        8'h00:        w_state_nxt = S_RESP;
                        8'h81, 8'h82: w_state_nxt = S_ADDR;
                        default:      w_state_nxt = S_IDLE;
                    endcase
                end
                S_ADDR: if (w_byte && r_bcnt == 2'd3) w_state_nxt = S_LEN;
                S_LEN: if (w_byte && r_bcnt == 2'd3) begin
                    if (w_len_new[1:0] != 2'd0 || w_len_new == 32'd0) w_state_nxt = S_IDLE;
                    else w_state_nxt = r_we ? S_DATA : S_BUS;
                end
                S_DATA: if (w_byte && r_bcnt == 2'd3) w_state_nxt = S_BUS;
                S_BUS:  if (w_ack) w_state_nxt = (r_we && r_len != 32'd4) ? S_DATA : S_RESP;
                S_RESP: if (r_txn == 3'd0) w_state_nxt = (!r_we && r_len != 32'd0) ? S_BUS : S_IDLE;
                default: ;
            endcase
        end
    end

    // Parser datapath: collect address/length/data little-endian, track words left and reply bytes.
    always_ff @(posedge clk_i or negedge arst_i)
        if (!arst_i) begin
            r_bcnt <= '0; r_addr <= '0; r_len <= '0; r_wdata <= '0; r_txbuf <= '0;
            r_txn <= '0; r_we <= 1'b0; r_busy <= 1'b0; r_udm_rst <= 1'b0;
        end else begin
            if (w_sync) r_busy <= 1'b0;
            else if (w_req) r_busy <= 1'b1;
            else if (w_ack) r_busy <= 1'b0;
            if (w_tx_start) begin r_txbuf <= r_txbuf >> 8; r_txn <= r_txn - 1'b1; end
            if (w_sync) begin r_bcnt <= '0; r_len <= '0; r_txn <= '0; end
            else if (w_byte) begin
                case (r_state)
                    S_CMD: begin
                        r_we <= (r_rx_sh == 8'h81);
                        if (r_rx_sh == 8'h00) begin r_txbuf <= 32'h55; r_txn <= 3'd1; end
                        if (r_rx_sh == 8'h80) r_udm_rst <= 1'b1;
                        if (r_rx_sh == 8'hC0) r_udm_rst <= 1'b0;
                    end
                    S_ADDR: begin r_addr  <= {r_rx_sh, r_addr[31:8]};  r_bcnt <= r_bcnt + 1'b1; end
                    S_LEN:  begin r_len   <= w_len_new;                r_bcnt <= r_bcnt + 1'b1; end
                    S_DATA: begin r_wdata <= {r_rx_sh, r_wdata[31:8]}; r_bcnt <= r_bcnt + 1'b1; end
                    default: ;
                endcase
            end else if (r_state == S_BUS && w_ack) begin
                r_addr  <= r_addr + 32'd4;
                r_len   <= r_len - 32'd4;
                r_txbuf <= r_we ? 32'd0 : w_rdata;
                r_txn   <= r_we ? ((r_len == 32'd4) ? 3'd1 : 3'd0) : 3'd4;
            end
        end

    assign w_is_ram = (r_addr[31:2] < 30'(mem_size));

    // On-chip RAM, word addressed; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (w_req && w_is_ram && r_we) r_mem[r_addr[AW+1:2]] <= r_wdata;
        if (w_req && w_is_ram) r_ram_q <= r_mem[r_addr[AW+1:2]];
    end

    assign w_btn_rise = (r_btn_s[1] != r_btn_db) && (&r_db_cnt) && r_btn_s[1];

    // Bus slaves: ack timing, CSRs, input synchronizers and button debounce; cleared by srst.
    always_ff @(posedge clk_i or negedge arst_i)
        if (!arst_i) begin
            r_ack1 <= 1'b0; r_ack_d <= 1'b0; r_ack2 <= 1'b0; r_sel_ram <= 1'b0; r_csr_q <= '0;
            r_led <= '0; r_irq_en <= '0; r_pend <= 1'b0; r_btn_s <= '0; r_btn_db <= 1'b0;
            r_db_cnt <= '0; r_gpio_s1 <= '0; r_gpio_s2 <= '0;
        end else if (r_srst) begin
            r_ack1 <= 1'b0; r_ack_d <= 1'b0; r_ack2 <= 1'b0; r_sel_ram <= 1'b0; r_csr_q <= '0;
            r_led <= '0; r_irq_en <= '0; r_pend <= 1'b0; r_btn_s <= '0; r_btn_db <= 1'b0;
            r_db_cnt <= '0; r_gpio_s1 <= '0; r_gpio_s2 <= '0;
        end else begin
            r_ack1  <= w_req && !(w_is_ram && DLY);
            r_ack_d <= w_req && w_is_ram && DLY;
            r_ack2  <= r_ack_d;
            if (w_req) begin
                r_sel_ram <= w_is_ram;
                case (r_addr)
                    32'h0010_0010: r_csr_q <= r_irq_en;
                    32'h0010_0014: r_csr_q <= {29'd0, r_pend, 2'd0};
                    32'h8000_0000: r_csr_q <= r_led;
                    32'h8000_0004: r_csr_q <= r_gpio_s2;
                    default:       r_csr_q <= '0;
                endcase
                if (r_we && r_addr == 32'h0010_0010) r_irq_en <= r_wdata;
                if (r_we && r_addr == 32'h8000_0000) r_led    <= r_wdata;
            end
            // Set wins over a simultaneous write-one-to-clear.
            r_pend <= (r_pend && !(w_req && r_we && r_addr == 32'h0010_0014 && r_wdata[2])) || w_btn_rise;
            r_btn_s   <= {r_btn_s[0], irq_btn_i};
            r_gpio_s1 <= gpio_bi;
            r_gpio_s2 <= r_gpio_s1;
            if (r_btn_s[1] == r_btn_db) r_db_cnt <= '0;
            else if (&r_db_cnt) begin r_btn_db <= r_btn_s[1]; r_db_cnt <= '0; end
            else r_db_cnt <= r_db_cnt + 1'b1;
        end

    assign w_ack   = r_ack1 | r_ack2;
    assign w_rdata = r_sel_ram ? r_ram_q : r_csr_q;
    assign gpio_bo = r_led;
    assign irq_o   = r_pend & r_irq_en[2];
endmodule

// File: tb/tb_sigma_soc.sv
// tb_sigma_soc: drives UDM frames into two sigma_soc instances (RAM ack delay off / on)
// sharing one RX line; reply bytes are checked against a per-instance expected-byte queue.
module tb_sigma_soc;
    localparam int DIV = 8;

    logic        clk = 1'b0;
    logic        arst = 1'b0;
    logic        btn = 1'b0;
    logic        rx = 1'b1;
    logic [31:0] gpio_bi = 32'd0;
    logic        tx0, tx1, irq0, irq1;
    logic [31:0] gpio_bo0, gpio_bo1;
    logic [7:0]  exp_q0[$];
    logic [7:0]  exp_q1[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    sigma_soc #(.UART_BAUD_DIV(DIV), .mem_size(1024), .delay_test_flag(0)) dut (
        .clk_i(clk), .arst_i(arst), .irq_btn_i(btn), .rx_i(rx), .tx_o(tx0),
        .gpio_bi(gpio_bi), .gpio_bo(gpio_bo0), .irq_o(irq0));

    sigma_soc #(.UART_BAUD_DIV(DIV), .mem_size(1024), .delay_test_flag(1)) dut_d (
        .clk_i(clk), .arst_i(arst), .irq_btn_i(btn), .rx_i(rx), .tx_o(tx1),
        .gpio_bi(gpio_bi), .gpio_bo(gpio_bo1), .irq_o(irq1));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic tx_of(input int k);
        return (k == 0) ? tx0 : tx1;
    endfunction

    // Decode reply bytes from one instance and compare with the oldest expectation.
    task automatic uart_mon(input int k);
        logic [7:0] b;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (tx_of(k) == 1'b0) begin
                repeat (DIV / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    b[i] = tx_of(k);
                end
                repeat (DIV) @(negedge clk);
                if (k == 0) begin
                    if (exp_q0.size() == 0) chk("uart0_unexpected", {24'd0, b}, 32'h100);
                    else begin e = exp_q0.pop_front(); chk("uart0_byte", {24'd0, b}, {24'd0, e}); end
                end else begin
                    if (exp_q1.size() == 0) chk("uart1_unexpected", {24'd0, b}, 32'h100);
                    else begin e = exp_q1.pop_front(); chk("uart1_byte", {24'd0, b}, {24'd0, e}); end
                end
            end
        end
    endtask

    initial uart_mon(0);
    initial uart_mon(1);

    task automatic send_byte(input logic [7:0] b);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rx = f[i];
            repeat (DIV - 1) @(negedge clk);
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic exp_byte(input logic [7:0] b);
        exp_q0.push_back(b);
        exp_q1.push_back(b);
    endtask

    task automatic exp_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) exp_byte(w[8*i +: 8]);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("drain0", exp_q0.size(), 0);
        chk("drain1", exp_q1.size(), 0);
        repeat (2 * DIV) @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        exp_byte(8'h00);
        send_byte(8'h55); send_byte(8'h81); send_word(a); send_word(32'd4); send_word(d);
        wait_drain();
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] d);
        exp_word(d);
        send_byte(8'h55); send_byte(8'h82); send_word(a); send_word(32'd4);
        wait_drain();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog got=%0d exp=%0d", n_cmp, -1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic old_v;
        logic new_v;
        // Reset state and release timing of srst
        repeat (3) @(negedge clk);
        chk("rst_tx", {31'd0, tx0}, 1);
        chk("rst_led", gpio_bo0, 0);
        chk("rst_irq", {31'd0, irq0}, 0);
        chk("rst_srst", {31'd0, dut.r_srst}, 1);
        arst = 1'b1;
        @(posedge clk); #1;
        chk("srst_edge1", {31'd0, dut.r_srst}, 1);
        chk("srst_edge1_d", {31'd0, dut_d.r_srst}, 1);
        @(posedge clk); #1;
        chk("srst_edge2", {31'd0, dut.r_srst}, 0);
        chk("srst_edge2_d", {31'd0, dut_d.r_srst}, 0);
        repeat (4 * DIV) @(negedge clk);

        // IDCODE
        exp_byte(8'h55);
        send_byte(8'h55); send_byte(8'h00);
        wait_drain();

        // Single word RAM write/read
        wr(32'h0, 32'hDEAD_BEEF);
        rd(32'h0, 32'hDEAD_BEEF);

        // Two-word burst with address increment
        exp_byte(8'h00);
        send_byte(8'h55); send_byte(8'h81); send_word(32'h10); send_word(32'd8);
        send_word(32'h1122_3344); send_word(32'hCAFE_F00D);
        wait_drain();
        exp_word(32'h1122_3344); exp_word(32'hCAFE_F00D);
        send_byte(8'h55); send_byte(8'h82); send_word(32'h10); send_word(32'd8);
        wait_drain();
        rd(32'h14, 32'hCAFE_F00D);

        // Length not a multiple of 4: no reply, parser still answers IDCODE afterwards
        send_byte(8'h55); send_byte(8'h82); send_word(32'h0); send_word(32'd3);
        exp_byte(8'h55);
        send_byte(8'h55); send_byte(8'h00);
        wait_drain();

        // Unmapped space reads zero and drops writes
        rd(32'h4000_0000, 32'h0);
        wr(32'h4000_0000, 32'h1234_5678);
        rd(32'h4000_0000, 32'h0);

        // Button IRQ: short pulse is filtered, long press sets IRQ_PEND bit 2
        wr(32'h0010_0010, 32'h4);
        rd(32'h0010_0010, 32'h4);
        @(negedge clk); btn = 1'b1;
        repeat (2) @(negedge clk); btn = 1'b0;
        repeat (20) @(negedge clk);
        chk("irq_short", {31'd0, irq0}, 0);
        chk("irq_short_d", {31'd0, irq1}, 0);
        rd(32'h0010_0014, 32'h0);
        btn = 1'b1;
        repeat (10) @(negedge clk); btn = 1'b0;
        repeat (10) @(negedge clk);
        chk("irq_long", {31'd0, irq0}, 1);
        chk("irq_long_d", {31'd0, irq1}, 1);
        rd(32'h0010_0014, 32'h4);
        wr(32'h0010_0014, 32'h4);
        chk("irq_clr", {31'd0, irq0}, 0);
        chk("irq_clr_d", {31'd0, irq1}, 0);

        // LED and switches
        wr(32'h8000_0000, 32'hA5);
        chk("led", gpio_bo0, 32'hA5);
        chk("led_d", gpio_bo1, 32'hA5);
        rd(32'h8000_0000, 32'hA5);
        gpio_bi = 32'h100;
        rd(32'h8000_0004, 32'h100);
        wr(32'h8000_0004, 32'hFFFF_FFFF);
        rd(32'h8000_0004, 32'h100);

        // Switch synchronizer latency
        old_v = 1'b0;
        gpio_bi = 32'h0;
        repeat (28) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            new_v = ~old_v;
            @(negedge clk); gpio_bi = {31'd0, new_v};
            @(posedge clk); #1;
            chk("sw_lat1", dut.r_gpio_s2, {31'd0, old_v});
            @(posedge clk); #1;
            chk("sw_lat2", dut.r_gpio_s2, {31'd0, new_v});
            old_v = new_v;
            repeat (26) @(negedge clk);
        end

        // UDM-held reset
        send_byte(8'h55); send_byte(8'h80);
        repeat (20) @(negedge clk);
        chk("udm_srst_hi", {31'd0, dut.r_srst}, 1);
        chk("udm_srst_led", gpio_bo0, 0);
        chk("udm_srst_led_d", gpio_bo1, 0);
        send_byte(8'h55); send_byte(8'hC0);
        repeat (5) @(negedge clk);
        chk("udm_srst_lo", {31'd0, dut.r_srst}, 0);
        wr(32'h8000_0000, 32'h3C);
        chk("led_after", gpio_bo0, 32'h3C);
        rd(32'h0, 32'hDEAD_BEEF);

        // arst in the middle of a frame
        send_byte(8'h55); send_byte(8'h81); send_byte(8'h00); send_byte(8'h00);
        @(negedge clk); arst = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_led", gpio_bo0, 0);
        chk("mid_state", 32'(dut.r_state), 0);
        chk("mid_state_d", 32'(dut_d.r_state), 0);
        arst = 1'b1;
        repeat (5) @(negedge clk);
        exp_byte(8'h55);
        send_byte(8'h55); send_byte(8'h00);
        wait_drain();

        chk("q0_left", exp_q0.size(), 0);
        chk("q1_left", exp_q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
